// File: rtl/load_store_unit.sv
// Load/store initiator for a 64-bit-word data memory: byte-address decode,
// lane extraction with sign/zero extension, and read-modify-write for partial stores.
module load_store_unit #(
    parameter int DEPTH_LOG2 = 7,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] readAddress,
    output logic [63:0] writeAddress,
    output logic [63:0] writeData,
    input  logic [63:0] readData
);

    localparam int HI = DEPTH_LOG2 + 3;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic        signed_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic [63:0] rword_q;

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Right-shift that brings the addressed field down to bit 0.
    function automatic logic [5:0] lane_shift(input logic [2:0] off, input logic [1:0] size);
        logic [2:0] last;
        logic [2:0] lane;
        last = (3'd1 << size) - 3'd1;
        lane = BIG_ENDIAN ? (3'd7 - off - last) : off;
        return {lane, 3'b000};
    endfunction

    function automatic logic access_err(input logic [63:0] addr, input logic [1:0] size);
        logic [2:0] align;
        align = (3'd1 << size) - 3'd1;
        return (|(addr[2:0] & align)) || (|addr[63:HI]);
    endfunction

    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return {{(64 - DEPTH_LOG2){1'b0}}, addr[HI-1:3]};
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic [63:0] mask;
        logic [63:0] field;
        logic        msb;
        mask  = lane_mask(size);
        field = (word >> lane_shift(off, size)) & mask;
        case (size)
            2'd0:    msb = field[7];
            2'd1:    msb = field[15];
            2'd2:    msb = field[31];
            default: msb = 1'b0;
        endcase
        if (sgn && msb) begin
            field = field | ~mask;
        end
        return field;
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] word, input logic [63:0] wdata,
                                                input logic [2:0] off, input logic [1:0] size);
        logic [63:0] mask;
        logic [5:0]  sh;
        mask = lane_mask(size);
        sh   = lane_shift(off, size);
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (access_err(req_addr, req_size)) begin
                        state_nx = RESP;
                    end else if (req_we && (req_size == 2'd3)) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch on accept; memory word capture on leaving RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 3'd0;
            wdata_q      <= 64'd0;
            rword_q      <= 64'd0;
            readAddress  <= 64'd0;
            writeAddress <= 64'd0;
            writeData    <= 64'd0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                we_q         <= req_we;
                signed_q     <= req_signed;
                err_q        <= access_err(req_addr, req_size);
                size_q       <= req_size;
                off_q        <= req_addr[2:0];
                wdata_q      <= req_wdata;
                readAddress  <= word_index(req_addr);
                writeAddress <= word_index(req_addr);
                if (req_we && (req_size == 2'd3)) begin
                    writeData <= req_wdata;
                end
            end
            if (state == RD) begin
                rword_q <= readData;
                if (we_q) begin
                    writeData <= store_merge(readData, wdata_q, off_q, size_q);
                end
            end
        end
    end

    assign req_ready  = (state == IDLE) && rst_n;
    assign MemRead    = (state == RD);
    assign MemWrite   = (state == WR);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = ((state == RESP) && !we_q && !err_q)
                        ? load_extend(rword_q, off_q, size_q, signed_q) : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array memory reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] readAddress;
    logic [63:0] writeAddress;
    logic [63:0] writeData;
    logic [63:0] readData;

    load_store_unit #(.DEPTH_LOG2(7), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .readAddress(readAddress), .writeAddress(writeAddress),
        .writeData(writeData), .readData(readData)
    );

    always #5 clk = ~clk;

    // DataMemory model plus a preload port used while the DUT is in reset.
    logic [63:0] mem [0:127];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = 7'd0;
    logic [63:0] pre_data = 64'd0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (MemWrite) mem[writeAddress[6:0]] <= writeData;
    end
    assign readData = mem[readAddress[6:0]];

    // Reference: 1 KiB byte array, byte address a is the a-th byte in big-endian order.
    logic [7:0] rb [0:1023];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [63:0] idx;
        logic [63:0] wdata;
        int          acc;
        int          rd_base;
        int          wr_base;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    exp_t        e;
    int          nchk = 0;
    int          nerr = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] last_rdata = 64'd0;
    logic [63:0] last_wdata = 64'd0;
    logic        last_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input int a, input int n, input bit sgn);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(rb[a + i]);
        if (sgn && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input int a, input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) rb[a + i] = d[8 * (n - 1 - i) +: 8];
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        v = 64'd0;
        for (int o = 0; o < 8; o++) v = (v << 8) | 64'(rb[8 * w + o]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (MemRead && MemWrite) chk("strobe_overlap", 64'd1, 64'd0);
        if (MemRead) begin
            rd_cnt = rd_cnt + 1;
            chk("rd_addr", readAddress, cur.idx);
        end
        if (MemWrite) begin
            wr_cnt = wr_cnt + 1;
            chk("wr_addr", writeAddress, cur.idx);
            chk("wr_data", writeData, cur.wdata);
            last_wdata = writeData;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_resp", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                chk("n_memread", 64'(rd_cnt - e.rd_base), 64'(e.nrd));
                chk("n_memwrite", 64'(wr_cnt - e.wr_base), 64'(e.nwr));
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] wdata, input bit track);
        exp_t x;
        int   n;
        int   t;
        bit   bad;
        n   = 1 << size;
        bad = (addr % 64'(n) != 64'd0) || (addr >= 64'd1024);
        x.idx   = {57'd0, addr[9:3]};
        x.err   = bad;
        x.lat   = bad ? 1 : (we && size == 2'd3) ? 2 : we ? 3 : 2;
        x.nrd   = (bad || (we && size == 2'd3)) ? 0 : 1;
        x.nwr   = (!bad && we) ? 1 : 0;
        x.rdata = (!bad && !we) ? ref_load(int'(addr[9:0]), n, sgn) : 64'd0;
        x.wdata = 64'd0;
        if (!bad && we && track) begin
            ref_store(int'(addr[9:0]), n, wdata);
            x.wdata = ref_word(int'(addr[9:3]));
        end
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        x.acc     = cyc;
        x.rd_base = rd_cnt;
        x.wr_base = wr_cnt;
        cur       = x;
        if (track) begin
            sb_q.push_back(x);
            t = 0;
            while (sb_q.size() != 0 && t < 10) begin
                @(posedge clk);
                t++;
            end
            if (sb_q.size() != 0) begin
                chk("resp_timeout", 64'd0, 64'd1);
                sb_q.delete();
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  sz;
        logic [63:0] a;
        int          r;
        for (int w = 0; w < 128; w++) begin
            d = (w == 2) ? 64'h0123_4567_89AB_CDEF : {$urandom, $urandom};
            for (int o = 0; o < 8; o++) rb[8 * w + o] = d[63 - 8 * o -: 8];
            pre_we   = 1'b1;
            pre_idx  = 7'(w);
            pre_data = d;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_memread", 64'(MemRead), 64'd0);
        chk("rst_memwrite", 64'(MemWrite), 64'd0);
        chk("rst_read_addr", readAddress, 64'd0);
        chk("rst_write_addr", writeAddress, 64'd0);
        chk("rst_write_data", writeData, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 2'd0, 1'b0, 64'h11, 64'd0, 1'b1);
        chk("tp_byte_load", last_rdata, 64'h23);
        issue(1'b0, 2'd1, 1'b1, 64'h14, 64'd0, 1'b1);
        chk("tp_half_signed", last_rdata, 64'hFFFF_FFFF_FFFF_89AB);
        issue(1'b0, 2'd1, 1'b0, 64'h14, 64'd0, 1'b1);
        chk("tp_half_unsigned", last_rdata, 64'h0000_0000_0000_89AB);
        issue(1'b1, 2'd0, 1'b0, 64'h17, 64'h5A, 1'b1);
        chk("tp_byte_store_wdata", last_wdata, 64'h0123_4567_89AB_CD5A);
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b1);
        chk("tp_dword_reload", last_rdata, 64'h0123_4567_89AB_CD5A);
        issue(1'b1, 2'd3, 1'b0, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        chk("tp_dword_store_mem", mem[3], 64'hDEAD_BEEF_CAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, 64'h12, 64'd0, 1'b1);
        chk("tp_misaligned_err", 64'(last_err), 64'd1);
        issue(1'b0, 2'd2, 1'b0, 64'h400, 64'd0, 1'b1);
        chk("tp_range_err", 64'(last_err), 64'd1);
        chk("tp_err_mem_intact", mem[2], 64'h0123_4567_89AB_CD5A);

        issue(1'b1, 2'd0, 1'b0, 64'h20, 64'h77, 1'b0);
        @(negedge clk);
        chk("abort_in_rd", 64'(MemRead), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_memread", 64'(MemRead), 64'd0);
        chk("abort_memwrite", 64'(MemWrite), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_read_addr", readAddress, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after", 64'(req_ready), 64'd1);
        chk("abort_mem_intact", mem[4], ref_word(4));
        issue(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 1'b1);

        for (int k = 0; k < 80; k++) begin
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            a  = 64'($urandom_range(0, 1023));
            if (r < 7) a = a - (a % 64'(1 << sz));
            if (r == 9) a[$urandom_range(10, 63)] = 1'b1;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 1'b1);
        end

        for (int w = 0; w < 128; w++) chk("final_mem", mem[w], ref_word(w));

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
